csr_priv_arbiter: RTL and testbench
===================================

# csr_priv_arbiter

Two-port arbitrated access controller for a small bank of machine-level control/status registers. It round-robins requests from two requesters, such as a core load/store port and a debug port. Every access is checked against a per-register privilege mask, and out-of-privilege or badly decoded accesses are squashed with an exception response. Privilege violations are counted for the security monitor. It sits between the requesters and the CSR storage and is the single point of enforcement: no register, including stack and PC shadow registers, bypasses the check.

## Interface
- DATA_W, 32, register and data width
- NREGS, 8, number of registers; register i is at BASE_ADDR + 4*i
- BASE_ADDR, 12'h060, byte address of register 0
- PROT_MASK, 8'b0000_0110, bit i = 1 makes register i machine-only (default protects 0x064 stack reg and 0x068 PC reg)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid per requester
- req_ready  out  2  request accepted (handshake completes when valid & ready)
- req_write  in  2  1 = write, 0 = read
- req_priv  in  2x2  privilege of requester (2'b11 = machine)
- req_addr  in  2x12  byte address
- req_wdata  in  2xDATA_W  write data
- rsp_valid  out  2  one-cycle response strobe to the granted requester
- rsp_rdata  out  DATA_W  read data, shared by both requesters
- rsp_except  out  1  access denied; qualified by rsp_valid
- viol_count  out  8  saturating count of privilege violations

## Operation
- FSM states: IDLE -> CHECK -> RESP -> IDLE. No other transitions except reset.
- IDLE:
  - If any req_valid is set, grant one requester. If exactly one is valid, grant it.
  - If both are valid, grant the one not granted last (last_grant pointer).
  - req_ready[g] is driven combinationally high only in IDLE and only for the winner.
  - On that edge, capture write, priv, addr and wdata; update last_grant = g; go to CHECK.
- CHECK: decode the captured request.
  - decode_err = addr[1:0] != 0, or addr < BASE_ADDR, or index (addr - BASE_ADDR) >> 2 >= NREGS.
  - priv_err = !decode_err & PROT_MASK[index] & (priv != 2'b11).
  - The privilege comparison is full 2-bit equality, never a bitwise AND.
  - except = decode_err | priv_err.
  - On the CHECK->RESP edge, for an allowed write: bank[index] <= wdata.
  - On the same edge, register rsp_rdata as bank[index] for an allowed read, and 0 otherwise (writes or except).
  - On the same edge, register rsp_except, and increment viol_count if priv_err, saturating at 8'hFF.
  - decode_err alone does not count as a violation.
- RESP: rsp_valid[g] = 1 for exactly this cycle, together with rsp_rdata and rsp_except. Then go to IDLE.
- A denied write leaves the bank unchanged. A denied read returns 0.
- No response backpressure: requesters must accept rsp_valid when it fires.

## Timing
- Reset values:
  - state IDLE
  - last_grant = 1, so requester 0 wins the first tie
  - all bank registers 0
  - req_ready 0 (outside IDLE), rsp_valid 2'b00, rsp_rdata 0, rsp_except 0, viol_count 0
- Latency: handshake in cycle T, CHECK in T+1, rsp_valid at T+2.
- Next handshake is possible at T+3, so peak throughput is 1 access per 3 cycles.
- A request arriving while not in IDLE waits (ready = 0); the requester holds valid and fields stable.
- Both requesters continuously valid: grants alternate 0,1,0,1...
- Reset asserted mid-CHECK or mid-RESP: abort immediately, no bank write, no rsp_valid, no counter update.
- viol_count at 8'hFF stays 8'hFF on further violations.
- Read-after-write to the same register from the other requester returns the new value, because the write lands before the next CHECK.

## Test plan
- After reset, req0 machine (priv 11) writes 0x064 with 0xDEADBEEF, then reads 0x064 -> first access: ready at T, rsp_valid[0] at T+2 with except 0; read returns 0xDEADBEEF.
- req1 priv 2'b01 writes 0x064 and 0x068 with 0x1234 -> both rsp_except 1 and rdata 0; bank keeps its old values; viol_count = 2.
- priv 2'b10 (top bit set) reads 0x068 -> except 1. priv 2'b01 reads unprotected 0x060 -> except 0 with data.
- Misaligned 0x061 and out-of-range 0x080 (NREGS = 8) -> except 1; viol_count unchanged.
- Both valid for 6 accesses from reset -> grant order 0,1,0,1,0,1, each spaced 3 cycles apart.
- 300 user-mode accesses to 0x064 -> viol_count saturates at 255.
- Assert rst during CHECK of a machine write -> bank register remains 0 and no rsp_valid.

Source files
------------

// File: rtl/csr_priv_arbiter_if.sv
// Request/response bundle between two CSR requesters and csr_priv_arbiter.
// Index [g] of each request field belongs to requester g; the read data and
// exception flag are shared and qualified by the per-requester rsp_valid bit.
interface csr_priv_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_write;
    logic [1:0][1:0]        req_priv;
    logic [1:0][11:0]       req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_except;

    // Requester side: drives requests, consumes handshake and responses.
    modport master (
        output req_valid, req_write, req_priv, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_except
    );

    // Arbiter side: consumes requests, drives handshake and responses.
    modport slave (
        input  req_valid, req_write, req_priv, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_except
    );
endinterface

// File: rtl/csr_priv_arbiter.sv
// Two-port round-robin arbiter in front of a small CSR bank. Each granted
// access is decoded and privilege-checked before it may touch the bank;
// denied accesses return an exception and privilege violations are counted.
// One access takes three cycles: IDLE (handshake) -> CHECK -> RESP.
module csr_priv_arbiter #(
    parameter int               DATA_W    = 32,
    parameter int               NREGS     = 8,
    parameter logic [11:0]      BASE_ADDR = 12'h060,
    parameter logic [NREGS-1:0] PROT_MASK = 8'b0000_0110
) (
    input  logic              clk,
    input  logic              rst,
    csr_priv_arbiter_if.slave bus,
    output logic [7:0]        viol_count
);
    localparam int         IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [9:0] NREGS_W   = 10'(NREGS);
    localparam logic [9:0] BASE_WORD = BASE_ADDR[11:2];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic              last_grant;
    logic              winner;
    logic              handshake;

    logic              cap_g;
    logic              cap_write;
    logic [1:0]        cap_priv;
    logic [11:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [DATA_W-1:0] bank [NREGS];
    logic [DATA_W-1:0] rdata_q;
    logic              except_q;

    logic [9:0]        word_off;
    logic [IDX_W-1:0]  idx;
    logic              decode_err;
    logic              priv_err;
    logic              except;

    // Pick the requester to grant: a lone requester wins, a tie goes to the
    // one that was not granted last.
    always_comb begin
        winner = 1'b0;
        if (bus.req_valid == 2'b11) begin
            winner = ~last_grant;
        end else if (bus.req_valid[1]) begin
            winner = 1'b1;
        end
    end

    // Next-state logic and the combinational ready handshake (IDLE only).
    always_comb begin
        // NOTE: every output of this block is given a default before the case,
        // so no path leaves one unassigned and no latch is inferred.
        state_next    = state;
        handshake     = 1'b0;
        bus.req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    handshake     = 1'b1;
                    bus.req_ready = winner ? 2'b10 : 2'b01;
                    state_next    = CHECK;
                end
            end
            CHECK:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode and privilege check of the captured request.
    always_comb begin
        word_off   = cap_addr[11:2] - BASE_WORD;
        idx        = word_off[IDX_W-1:0];
        decode_err = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR) ||
                     (word_off >= NREGS_W);
        // Full 2-bit equality: a privilege of 2'b10 or 2'b01 is not machine.
        priv_err   = !decode_err && PROT_MASK[idx] && (cap_priv != 2'b11);
        except     = decode_err || priv_err;
    end

    // Response strobe goes only to the requester that owns the access.
    always_comb begin
        bus.rsp_valid  = 2'b00;
        if (state == RESP) begin
            bus.rsp_valid = cap_g ? 2'b10 : 2'b01;
        end
        bus.rsp_rdata  = rdata_q;
        bus.rsp_except = except_q;
    end

    // State register, round-robin pointer and request capture on handshake.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design updates from the same pre-edge values.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_g      <= 1'b0;
            cap_write  <= 1'b0;
            cap_priv   <= 2'b00;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            state <= state_next;
            if (handshake) begin
                cap_g      <= winner;
                last_grant <= winner;
                cap_write  <= bus.req_write[winner];
                cap_priv   <= bus.req_priv[winner];
                cap_addr   <= bus.req_addr[winner];
                cap_wdata  <= bus.req_wdata[winner];
            end
        end
    end

    // CSR bank: only an allowed write leaving CHECK updates it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the bank is a flop array with an explicit reset because every
        // register must read 0 after reset; it is not a plain RAM.
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                bank[i] <= '0;
            end
        end else if (state == CHECK && cap_write && !except) begin
            bank[idx] <= cap_wdata;
        end
    end

    // Response data, exception flag and saturating violation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            except_q   <= 1'b0;
            viol_count <= 8'h00;
        end else if (state == CHECK) begin
            rdata_q  <= (!cap_write && !except) ? bank[idx] : '0;
            except_q <= except;
            if (priv_err && viol_count != 8'hFF) begin
                viol_count <= viol_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_csr_priv_arbiter.sv
// Self-checking bench for csr_priv_arbiter. A behavioural model (address
// arithmetic, an array for the bank, an integer counter) predicts every
// response; directed scenarios are followed by randomized traffic.
module tb_csr_priv_arbiter;
    localparam int          DW   = 32;
    localparam logic [11:0] BASE = 12'h060;
    localparam logic [7:0]  PROT = 8'b0000_0110;

    typedef struct {
        int          g;
        logic        wr;
        logic [1:0]  pv;
        logic [11:0] ad;
        logic [31:0] wd;
    } acc_t;

    typedef struct {
        int          g;
        logic [31:0] rd;
        logic        ex;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] viol_count;

    csr_priv_arbiter_if #(.DATA_W(DW)) bus ();

    csr_priv_arbiter #(
        .DATA_W   (DW),
        .NREGS    (8),
        .BASE_ADDR(BASE),
        .PROT_MASK(PROT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_bank [8];
    int          m_viol;
    logic        m_last;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 32'h0;
        m_viol = 0;
        m_last = 1'b1;
    endtask

    function automatic void model_access(input logic wr, input logic [1:0] pv,
                                         input logic [11:0] ad, input logic [31:0] wd,
                                         output logic [31:0] exp_rd, output logic exp_ex);
        int a = int'(ad);
        int base = int'(BASE);
        bit in_map;
        bit viol;
        int idx;
        in_map = (a % 4 == 0) && (a >= base) && ((a - base) / 4 < 8);
        idx    = in_map ? (a - base) / 4 : 0;
        viol   = in_map && PROT[idx] && (pv != 2'b11);
        if (viol) m_viol = (m_viol >= 255) ? 255 : m_viol + 1;
        exp_ex = !in_map || viol;
        exp_rd = 32'h0;
        if (!exp_ex) begin
            if (wr) m_bank[idx] = wd;
            else    exp_rd = m_bank[idx];
        end
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_priv  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One access from requester g; returns observations (lat = 99 on timeout).
    // Entered and left just after a rising edge.
    task automatic run_access(input int g, input logic wr, input logic [1:0] pv,
                              input logic [11:0] ad, input logic [31:0] wd,
                              output int lat, output logic [1:0] rv,
                              output logic [31:0] rd, output logic ex);
        bit got = 0;
        lat = 99; rv = 2'b00; rd = 32'h0; ex = 1'b0;
        bus.req_valid[g] = 1'b1;
        bus.req_write[g] = wr;
        bus.req_priv[g]  = pv;
        bus.req_addr[g]  = ad;
        bus.req_wdata[g] = wd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_ready[g]) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid[g] = 1'b0;
        if (got) begin
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (bus.rsp_valid != 2'b00) begin
                    lat = i; rv = bus.rsp_valid; rd = bus.rsp_rdata; ex = bus.rsp_except;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_except, bus.rsp_rdata, viol_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: ready=%b rsp_valid=%b except=%b rdata=%h viol=%0d, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_except, bus.rsp_rdata, viol_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_except, bus.rsp_rdata, viol_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b rsp_valid=%b except=%b rdata=%h viol=%0d, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_except, bus.rsp_rdata, viol_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_machine_rw();
        acc_t t[$];
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        t.push_back('{0, 1'b1, 2'b11, 12'h064, 32'hDEADBEEF});
        t.push_back('{0, 1'b0, 2'b11, 12'h064, 32'h0});
        foreach (t[k]) begin
            run_access(t[k].g, t[k].wr, t[k].pv, t[k].ad, t[k].wd, lat, rv, rd, ex);
            model_access(t[k].wr, t[k].pv, t[k].ad, t[k].wd, erd, eex);
            erv = (t[k].g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd) begin
                n_bad++;
                $display("FAIL machine_rw[%0d] addr=%h: got lat=%0d rv=%b ex=%b rd=%h want lat=2 rv=%b ex=%b rd=%h",
                         k, t[k].ad, lat, rv, ex, rd, erv, eex, erd);
            end
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL machine_readback: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_user_denied();
        acc_t t[$];
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        t.push_back('{0, 1'b1, 2'b11, 12'h068, 32'hCAFE0068});
        t.push_back('{1, 1'b1, 2'b01, 12'h064, 32'h00001234});
        t.push_back('{1, 1'b1, 2'b01, 12'h068, 32'h00001234});
        t.push_back('{0, 1'b0, 2'b11, 12'h064, 32'h0});
        t.push_back('{0, 1'b0, 2'b11, 12'h068, 32'h0});
        foreach (t[k]) begin
            run_access(t[k].g, t[k].wr, t[k].pv, t[k].ad, t[k].wd, lat, rv, rd, ex);
            model_access(t[k].wr, t[k].pv, t[k].ad, t[k].wd, erd, eex);
            erv = (t[k].g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd) begin
                n_bad++;
                $display("FAIL user_denied[%0d] addr=%h: got lat=%0d rv=%b ex=%b rd=%h want lat=2 rv=%b ex=%b rd=%h",
                         k, t[k].ad, lat, rv, ex, rd, erv, eex, erd);
            end
        end
        n_cmp++;
        if (viol_count !== 8'd2) begin
            n_bad++;
            $display("FAIL user_denied_viol: got %0d want 2", viol_count);
        end
    endtask

    task automatic test_priv_encoding();
        acc_t t[$];
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        t.push_back('{0, 1'b1, 2'b11, 12'h060, 32'h600D0060});
        t.push_back('{1, 1'b0, 2'b10, 12'h068, 32'h0});
        t.push_back('{1, 1'b0, 2'b01, 12'h060, 32'h0});
        t.push_back('{0, 1'b0, 2'b00, 12'h064, 32'h0});
        t.push_back('{1, 1'b0, 2'b11, 12'h068, 32'h0});
        t.push_back('{1, 1'b1, 2'b10, 12'h074, 32'h77777777});
        t.push_back('{0, 1'b0, 2'b00, 12'h074, 32'h0});
        foreach (t[k]) begin
            run_access(t[k].g, t[k].wr, t[k].pv, t[k].ad, t[k].wd, lat, rv, rd, ex);
            model_access(t[k].wr, t[k].pv, t[k].ad, t[k].wd, erd, eex);
            erv = (t[k].g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd) begin
                n_bad++;
                $display("FAIL priv_enc[%0d] addr=%h priv=%b: got lat=%0d rv=%b ex=%b rd=%h want lat=2 rv=%b ex=%b rd=%h",
                         k, t[k].ad, t[k].pv, lat, rv, ex, rd, erv, eex, erd);
            end
        end
        n_cmp++;
        if (viol_count !== 8'(m_viol)) begin
            n_bad++;
            $display("FAIL priv_enc_viol: got %0d want %0d", viol_count, m_viol);
        end
    endtask

    task automatic test_decode_err();
        acc_t t[$];
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        int viol_before = m_viol;
        t.push_back('{0, 1'b0, 2'b11, 12'h061, 32'h0});
        t.push_back('{0, 1'b1, 2'b11, 12'h080, 32'h12345678});
        t.push_back('{1, 1'b0, 2'b01, 12'h05C, 32'h0});
        t.push_back('{1, 1'b1, 2'b00, 12'h066, 32'h0BADF00D});
        t.push_back('{1, 1'b0, 2'b01, 12'h065, 32'h0});
        t.push_back('{0, 1'b1, 2'b11, 12'h07C, 32'h7C7C7C7C});
        t.push_back('{1, 1'b0, 2'b00, 12'h07C, 32'h0});
        foreach (t[k]) begin
            run_access(t[k].g, t[k].wr, t[k].pv, t[k].ad, t[k].wd, lat, rv, rd, ex);
            model_access(t[k].wr, t[k].pv, t[k].ad, t[k].wd, erd, eex);
            erv = (t[k].g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd) begin
                n_bad++;
                $display("FAIL decode[%0d] addr=%h: got lat=%0d rv=%b ex=%b rd=%h want lat=2 rv=%b ex=%b rd=%h",
                         k, t[k].ad, lat, rv, ex, rd, erv, eex, erd);
            end
        end
        n_cmp++;
        if (viol_count !== 8'(viol_before)) begin
            n_bad++;
            $display("FAIL decode_viol_unchanged: got %0d want %0d", viol_count, viol_before);
        end
    endtask

    task automatic test_random();
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        int g; logic wr; logic [1:0] pv; logic [11:0] ad; logic [31:0] wd;
        for (int k = 0; k < 80; k++) begin
            g  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            pv = 2'($urandom_range(0, 3));
            wd = $urandom;
            case ($urandom_range(0, 3))
                0:       ad = 12'(32'h060 + 4 * $urandom_range(0, 7));
                1:       ad = ($urandom_range(0, 1) != 0) ? 12'h064 : 12'h068;
                2:       ad = 12'(32'h050 + 4 * $urandom_range(0, 16));
                default: ad = 12'($urandom);
            endcase
            run_access(g, wr, pv, ad, wd, lat, rv, rd, ex);
            model_access(wr, pv, ad, wd, erd, eex);
            erv = (g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd) begin
                n_bad++;
                $display("FAIL random[%0d] g=%0d wr=%b priv=%b addr=%h: got lat=%0d rv=%b ex=%b rd=%h want lat=2 rv=%b ex=%b rd=%h",
                         k, g, wr, pv, ad, lat, rv, ex, rd, erv, eex, erd);
            end
        end
        n_cmp++;
        if (viol_count !== 8'(m_viol)) begin
            n_bad++;
            $display("FAIL random_viol: got %0d want %0d", viol_count, m_viol);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [1:0] rv, erv; logic [31:0] rd, erd; logic ex, eex;
        int g; logic [1:0] pv; logic [31:0] wd;
        for (int k = 0; k < 300; k++) begin
            g  = int'($urandom_range(0, 1));
            pv = 2'($urandom_range(0, 2));
            wd = $urandom;
            run_access(g, 1'b1, pv, 12'h064, wd, lat, rv, rd, ex);
            model_access(1'b1, pv, 12'h064, wd, erd, eex);
            erv = (g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (lat !== 2 || rv !== erv || ex !== eex || rd !== erd || viol_count !== 8'(m_viol)) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got lat=%0d rv=%b ex=%b rd=%h viol=%0d want lat=2 rv=%b ex=%b rd=%h viol=%0d",
                         k, lat, rv, ex, rd, viol_count, erv, eex, erd, m_viol);
            end
        end
        n_cmp++;
        if (viol_count !== 8'hFF) begin
            n_bad++;
            $display("FAIL saturate_final: got %0d want 255", viol_count);
        end
    endtask

    // Both requesters held valid from reset: grants must alternate 0,1,...
    // three cycles apart, and requester 1 reads what requester 0 just wrote.
    task automatic test_back_to_back();
        exp_t pend[$];
        exp_t e;
        int grants = 0;
        int last_cyc = 0;
        int eg;
        logic [31:0] erd; logic eex;
        logic [1:0] ewant;
        do_reset();
        bus.req_write = 2'b01;
        bus.req_priv  = {2'b11, 2'b11};
        bus.req_addr  = {12'h070, 12'h070};
        bus.req_wdata = {32'h0, 32'hA5A50070};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 60 && (grants < 6 || pend.size() > 0); i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                n_cmp++;
                if (pend.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_unexpected_rsp: rsp_valid=%b with nothing outstanding", bus.rsp_valid);
                end else begin
                    e = pend.pop_front();
                    ewant = (e.g == 1) ? 2'b10 : 2'b01;
                    if (bus.rsp_valid !== ewant || bus.rsp_except !== e.ex ||
                        bus.rsp_rdata !== e.rd || cyc !== e.cyc + 2) begin
                        n_bad++;
                        $display("FAIL b2b_rsp: got rv=%b ex=%b rd=%h cyc=%0d want rv=%b ex=%b rd=%h cyc=%0d",
                                 bus.rsp_valid, bus.rsp_except, bus.rsp_rdata, cyc, ewant, e.ex, e.rd, e.cyc + 2);
                    end
                end
            end
            if (bus.req_ready != 2'b00) begin
                eg    = m_last ? 0 : 1;
                ewant = (eg == 1) ? 2'b10 : 2'b01;
                n_cmp++;
                if (bus.req_ready !== ewant || (grants > 0 && cyc !== last_cyc + 3)) begin
                    n_bad++;
                    $display("FAIL b2b_grant[%0d]: got ready=%b cyc=%0d want ready=%b cyc=%0d",
                             grants, bus.req_ready, cyc, ewant, last_cyc + 3);
                end
                m_last   = (eg == 1);
                last_cyc = cyc;
                model_access(bus.req_write[eg], 2'b11, 12'h070, bus.req_wdata[eg], erd, eex);
                pend.push_back('{eg, erd, eex, cyc});
                grants++;
                if (grants == 6) begin
                    @(posedge clk);
                    #1 bus.req_valid = 2'b00;
                end
            end
        end
        n_cmp++;
        if (grants !== 6 || pend.size() !== 0) begin
            n_bad++;
            $display("FAIL b2b_timeout: grants=%0d outstanding=%0d want grants=6 outstanding=0",
                     grants, pend.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted while the access sits in CHECK must abort it entirely.
    task automatic test_reset_abort();
        acc_t t[$];
        int lat; logic [1:0] rv; logic [31:0] rd, erd; logic ex, eex;
        bit got;
        bit saw_rsp;
        t.push_back('{0, 1'b1, 2'b11, 12'h06C, 32'h5555AAAA});
        t.push_back('{1, 1'b1, 2'b01, 12'h064, 32'h99999999});
        foreach (t[k]) begin
            do_reset();
            got = 0;
            saw_rsp = 0;
            bus.req_valid[t[k].g] = 1'b1;
            bus.req_write[t[k].g] = t[k].wr;
            bus.req_priv[t[k].g]  = t[k].pv;
            bus.req_addr[t[k].g]  = t[k].ad;
            bus.req_wdata[t[k].g] = t[k].wd;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.req_ready[t[k].g]) begin
                    got = 1;
                    break;
                end
            end
            @(posedge clk);
            #1 bus.req_valid = 2'b00;
            rst = 1'b1;
            model_reset();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.rsp_valid != 2'b00) saw_rsp = 1;
            end
            n_cmp++;
            if (!got || saw_rsp || viol_count !== 8'h00) begin
                n_bad++;
                $display("FAIL abort[%0d]: handshake=%0d rsp_seen=%0d viol=%0d want handshake=1 rsp_seen=0 viol=0",
                         k, got, saw_rsp, viol_count);
            end
            @(posedge clk);
            #1 rst = 1'b0;
            run_access(0, 1'b0, 2'b11, t[k].ad, 32'h0, lat, rv, rd, ex);
            model_access(1'b0, 2'b11, t[k].ad, 32'h0, erd, eex);
            n_cmp++;
            if (lat !== 2 || rv !== 2'b01 || ex !== eex || rd !== erd || viol_count !== 8'h00) begin
                n_bad++;
                $display("FAIL abort_readback[%0d] addr=%h: got lat=%0d rv=%b ex=%b rd=%h viol=%0d want lat=2 rv=01 ex=%b rd=%h viol=0",
                         k, t[k].ad, lat, rv, ex, rd, viol_count, eex, erd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_machine_rw();
        test_user_denied();
        test_priv_encoding();
        test_decode_err();
        test_random();
        test_saturation();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
